lut_12bit_1s: RTL and testbench
===============================

# lut_12bit_1s

Registered 12-bit population counter: counts the `1` bits in a 12-bit input word and presents the result (0..12) on a 4-bit output one clock after capture. Counting uses three 4-bit nibble lookup tables and an adder. It is a leaf utility for status/occupancy logic anywhere a set-bit count of a 12-bit vector is needed.

## Interface
- No parameters; widths are fixed at 12-bit input and 4-bit count.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: capture enable; `bits` is sampled only when high.
- `bits` input 12: word whose set bits are counted.
- `count` output 4: registered number of `1`s in the last captured word, 0..12.
- `out_valid` output 1: registered copy of `in_valid`; high for exactly the cycle after each capture.
- `is_zero` output 1: present only with `LUT_12BIT_1S_FLAGS_EN`; registered, `count == 0`.
- `is_full` output 1: present only with `LUT_12BIT_1S_FLAGS_EN`; registered, `count == 12`.

## Operation
- Split `bits` into nibbles `bits[3:0]`, `bits[7:4]` and `bits[11:8]`.
- Each nibble indexes an identical 16-entry constant LUT with 3-bit entries (0..4). Entry = popcount of the index, e.g. 0x0→0, 0x7→3, 0xF→4.
- Sum the three LUT outputs into 4 bits. The maximum is 12, so overflow cannot occur and no saturation is needed.
- On a rising edge with `in_valid=1`, load the sum into `count` (and the flags, if built in).
- With `in_valid=0`, `count` and the flags hold their previous values.
- `out_valid` is always loaded from `in_valid` on every edge.
- Purely feed-forward: no state machine, no backpressure. A new word may be accepted every cycle.
- Any `bits` value is legal, and there are no X-propagation special cases.

## Timing
- Latency is 1 cycle: `bits` sampled at edge N appears on `count` immediately after edge N; `out_valid` is high during cycle N+1.
- Throughput is 1 word per clock.
- Reset values: `count=0`, `out_valid=0`, `is_zero=1`, `is_full=0`.
- Reset applies asynchronously on `rst` assertion, independent of `clk`.
- Reset mid-stream discards any pending capture. The first valid result after release follows the first edge with `in_valid=1`.
- If `rst` and `in_valid` are high at the same edge, reset wins.
- The combinational path `bits`→LUT→3-input add→register must close within one clock period. No output depends combinationally on any input.

## Configuration
- Macro `LUT_12BIT_1S_FLAGS_EN`:
  - Defined: `is_zero` and `is_full` ports and their registers exist, updated under the same enable as `count`.
  - Undefined: these ports and registers are absent. `count` and `out_valid` behaviour is identical in both builds.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `count=0` and `out_valid=0` immediately (`is_zero=1` if flags built). Drive `in_valid=1` and `bits=12'hFFF` during reset → `count` stays 0 until release.
- Exhaustive: after reset, sweep `bits` 0..4095 with `in_valid=1`, one value per cycle → each cycle `count` equals the reference popcount of the previous cycle's word. Spot checks: 12'h000→0, 12'h001→1, 12'h0F0→4, 12'hAAA→6, 12'h7FF→11, 12'hFFF→12.
- Hold: capture 12'h0F3 (`count=6`), then drop `in_valid` and change `bits` to 12'hFFF for 3 cycles → `count` stays 6 and `out_valid=0`.
- Back-to-back: alternate 12'hFFF and 12'h000 every cycle with `in_valid=1` → `count` alternates 12/0 with 1-cycle lag and `out_valid` stays high.
- Flags build: 12'h000 → `is_zero=1`, `is_full=0`; 12'hFFF → `is_zero=0`, `is_full=1`; 12'h800 → both 0.
- Reset mid-stream: during the sweep, pulse `rst` for 2 ns between edges → outputs clear at once, and counting resumes correctly at the next edge with `in_valid=1`.

Source files
------------

// File: rtl/lut_12bit_1s.sv
// lut_12bit_1s: registered 12-bit population counter.
// Three identical nibble lookup tables feed a 3-input adder; the sum is
// registered under in_valid. Optional zero/full flags are built only when
// the macro LUT_12BIT_1S_FLAGS_EN is defined.
module lut_12bit_1s (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [11:0] bits,
  output logic [3:0]  count,
  output logic        out_valid
`ifdef LUT_12BIT_1S_FLAGS_EN
  ,
  output logic        is_zero,
  output logic        is_full
`endif
);

  // 16-entry constant table: number of set bits in a 4-bit index (0..4).
  function automatic logic [2:0] nibble_lut(input logic [3:0] idx);
    logic [2:0] val;
    case (idx)
      4'h0: val = 3'd0;
      4'h1: val = 3'd1;
      4'h2: val = 3'd1;
      4'h3: val = 3'd2;
      4'h4: val = 3'd1;
      4'h5: val = 3'd2;
      4'h6: val = 3'd2;
      4'h7: val = 3'd3;
      4'h8: val = 3'd1;
      4'h9: val = 3'd2;
      4'hA: val = 3'd2;
      4'hB: val = 3'd3;
      4'hC: val = 3'd2;
      4'hD: val = 3'd3;
      4'hE: val = 3'd3;
      default: val = 3'd4;
    endcase
    return val;
  endfunction

  logic [2:0] pop_lo;
  logic [2:0] pop_mid;
  logic [2:0] pop_hi;
  logic [3:0] pop_sum;

  // Look up each nibble and add; the total tops out at 12 so 4 bits never overflow.
  always_comb begin
    pop_lo  = nibble_lut(bits[3:0]);
    pop_mid = nibble_lut(bits[7:4]);
    pop_hi  = nibble_lut(bits[11:8]);
    pop_sum = {1'b0, pop_lo} + {1'b0, pop_mid} + {1'b0, pop_hi};
  end

  // Result register: loads the sum only on a valid capture, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (in_valid) begin
      count <= pop_sum;
    end
  end

  // Valid register: follows in_valid every edge, giving a one-cycle strobe per capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

`ifdef LUT_12BIT_1S_FLAGS_EN
  // Flag registers: decoded from the same sum and enabled exactly like count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_zero <= 1'b1;
      is_full <= 1'b0;
    end else if (in_valid) begin
      is_zero <= (pop_sum == 4'd0);
      is_full <= (pop_sum == 4'd12);
    end
  end
`endif

endmodule

// File: tb/tb_lut_12bit_1s.sv
// Self-checking bench for lut_12bit_1s with directed vectors and an
// exhaustive sweep. Flag checks are compiled in with LUT_12BIT_1S_FLAGS_EN.
module tb_lut_12bit_1s;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [11:0] bits;
  logic [3:0]  count;
  logic        out_valid;
`ifdef LUT_12BIT_1S_FLAGS_EN
  logic        is_zero;
  logic        is_full;
`endif

  int passed = 0;
  int total  = 0;

  lut_12bit_1s dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .bits      (bits),
    .count     (count),
    .out_valid (out_valid)
`ifdef LUT_12BIT_1S_FLAGS_EN
    ,
    .is_zero   (is_zero),
    .is_full   (is_full)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference popcount by bit-by-bit loop.
  function automatic logic [3:0] ref_pop(input logic [11:0] w);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 12; k++) n = n + {3'd0, w[k]};
    return n;
  endfunction

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; bits = 12'h000;
    step(); step();
    if (count !== 4'd0) $display("[TB] FAIL reset_count actual=%0d required=0", count); else passed++;
    total++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid actual=%b required=0", out_valid); else passed++;
    total++;
`ifdef LUT_12BIT_1S_FLAGS_EN
    if (is_zero !== 1'b1 || is_full !== 1'b0)
      $display("[TB] FAIL reset_flags actual=%b%b required=10", is_zero, is_full);
    else passed++;
    total++;
`endif
    rst = 1'b0;
    in_valid = 1'b1; bits = 12'hFFF;
    step();
    if (count !== 4'd12) $display("[TB] FAIL pre_reset_capture actual=%0d required=12", count); else passed++;
    total++;
    // Assert reset mid-cycle with a capture pending; outputs must clear at once.
    #2 rst = 1'b1;
    #1;
    if (count !== 4'd0 || out_valid !== 1'b0)
      $display("[TB] FAIL async_reset actual=%0d/%b required=0/0", count, out_valid);
    else passed++;
    total++;
`ifdef LUT_12BIT_1S_FLAGS_EN
    if (is_zero !== 1'b1) $display("[TB] FAIL async_reset_is_zero actual=%b required=1", is_zero); else passed++;
    total++;
`endif
    step(); step();
    if (count !== 4'd0 || out_valid !== 1'b0)
      $display("[TB] FAIL reset_wins actual=%0d/%b required=0/0", count, out_valid);
    else passed++;
    total++;
    // Release between edges; the next edge captures 12'hFFF.
    #2 rst = 1'b0;
    step();
    if (count !== 4'd12 || out_valid !== 1'b1)
      $display("[TB] FAIL post_release actual=%0d/%b required=12/1", count, out_valid);
    else passed++;
    total++;
  endtask

  task automatic test_spot();
    logic [11:0] words [6];
    logic [3:0]  want  [6];
    words = '{12'h000, 12'h001, 12'h0F0, 12'hAAA, 12'h7FF, 12'hFFF};
    want  = '{4'd0, 4'd1, 4'd4, 4'd6, 4'd11, 4'd12};
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bits = words[i];
      step();
      if (count !== want[i] || out_valid !== 1'b1)
        $display("[TB] FAIL spot_%03h actual=%0d/%b required=%0d/1", words[i], count, out_valid, want[i]);
      else passed++;
      total++;
    end
  endtask

  task automatic test_sweep();
    in_valid = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      bits = 12'(i);
      if (i == 2000) begin
        // Short reset pulse between edges discards the pending capture.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        if (count !== 4'd0 || out_valid !== 1'b0)
          $display("[TB] FAIL midstream_reset actual=%0d/%b required=0/0", count, out_valid);
        else passed++;
        total++;
      end
      step();
      if (count !== ref_pop(12'(i)) || out_valid !== 1'b1)
        $display("[TB] FAIL sweep_%03h actual=%0d/%b required=%0d/1", i, count, out_valid, ref_pop(12'(i)));
      else passed++;
      total++;
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b1; bits = 12'h0F3;
    step();
    if (count !== 4'd6) $display("[TB] FAIL hold_capture actual=%0d required=6", count); else passed++;
    total++;
    in_valid = 1'b0; bits = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      if (count !== 4'd6 || out_valid !== 1'b0)
        $display("[TB] FAIL hold_%0d actual=%0d/%b required=6/0", i, count, out_valid);
      else passed++;
      total++;
`ifdef LUT_12BIT_1S_FLAGS_EN
      if (is_zero !== 1'b0 || is_full !== 1'b0)
        $display("[TB] FAIL hold_flags_%0d actual=%b%b required=00", i, is_zero, is_full);
      else passed++;
      total++;
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bits = (i % 2 == 0) ? 12'hFFF : 12'h000;
      want = (i % 2 == 0) ? 4'd12 : 4'd0;
      step();
      if (count !== want || out_valid !== 1'b1)
        $display("[TB] FAIL b2b_%0d actual=%0d/%b required=%0d/1", i, count, out_valid, want);
      else passed++;
      total++;
    end
  endtask

`ifdef LUT_12BIT_1S_FLAGS_EN
  task automatic test_flags();
    logic [11:0] words [3];
    logic [1:0]  want  [3];
    words = '{12'h000, 12'hFFF, 12'h800};
    want  = '{2'b10, 2'b01, 2'b00};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bits = words[i];
      step();
      if ({is_zero, is_full} !== want[i])
        $display("[TB] FAIL flags_%03h actual=%b%b required=%b", words[i], is_zero, is_full, want[i]);
      else passed++;
      total++;
    end
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_spot();
    test_sweep();
    test_hold();
    test_back_to_back();
`ifdef LUT_12BIT_1S_FLAGS_EN
    test_flags();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
